// File: rtl/nes_ppu_pkg.sv
// Shared PPU types: nametable mirroring modes, decode window and clear-FSM states.
// Imported by the nametable memory and its testbench.
package nes_ppu_pkg;

    typedef enum logic [2:0] {
        MIR_HORIZ    = 3'd0,
        MIR_VERT     = 3'd1,
        MIR_SINGLE_A = 3'd2,
        MIR_SINGLE_B = 3'd3,
        MIR_FOUR     = 3'd4
    } mirror_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } nt_state_t;

    localparam logic [13:0] NT_BASE = 14'h2000;
    localparam logic [13:0] NT_LAST = 14'h3EFF;

    function automatic logic nt_hit(input logic [13:0] a);
        return (a >= NT_BASE) && (a <= NT_LAST);
    endfunction

endpackage

// File: rtl/nt_ram_sp.sv
// Single-port synchronous RAM, read-first, no reset; maps onto a block RAM.
// The read register only loads when re is set, so it holds between reads.
module nt_ram_sp #(
    parameter int DATA_W = 8,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/nametable_vram.sv
// PPU nametable memory: $2000-$3EFF decode, cartridge mirroring onto 2 or 4 banks,
// 1-cycle registered reads and an optional zero-fill of the whole RAM after reset.
module nametable_vram
    import nes_ppu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BANK_AW  = 10,
    parameter int NBANKS   = 2,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        mirror,
    input  logic [13:0]       addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int BW   = $clog2(NBANKS);
    localparam int PA_W = BANK_AW + BW;

    nt_state_t          state_q;
    logic [PA_W-1:0]    cnt_q;
    logic [PA_W-1:0]    cnt_d;
    logic               busy_q;
    logic               rvalid_q;
    logic               zero_q;

    logic               hit;
    logic [BW-1:0]      bank;
    logic [PA_W-1:0]    phys;
    logic               clearing;
    logic               ram_we;
    logic               ram_re;
    logic [PA_W-1:0]    ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    // $3000-$3EFF aliases down because only addr[11:0] feeds the bank/offset.
    always_comb begin
        hit = nt_hit(addr);
        case (mirror)
            MIR_VERT:     bank = BW'(addr[10]);
            MIR_SINGLE_A: bank = '0;
            MIR_SINGLE_B: bank = BW'(1);
            MIR_FOUR:     bank = (NBANKS == 4) ? BW'(addr[11:10]) : BW'(addr[10]);
            default:      bank = BW'(addr[11]);
        endcase
        phys = {bank, addr[BANK_AW-1:0]};
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign cnt_d     = cnt_q + PA_W'(1);
    assign ram_we    = clearing | (wr & hit);
    assign ram_re    = ~clearing & rd & hit;
    assign ram_addr  = clearing ? cnt_q : phys;
    assign ram_wdata = clearing ? '0 : wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= (CLEAR_EN != 0);
            rvalid_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rvalid_q <= 1'b0;
                    cnt_q    <= cnt_d;
                    if (cnt_q == {PA_W{1'b1}}) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    rvalid_q <= rd;
                    // zero_q masks the RAM output after a miss read or reset.
                    if (rd) begin
                        zero_q <= ~hit;
                    end
                end
            endcase
        end
    end

    nt_ram_sp #(
        .DATA_W (DATA_W),
        .AW     (PA_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    assign rdata  = zero_q ? '0 : ram_rdata;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;

endmodule
